// File: rtl/inst_fetcher_pkg.sv
// rtl/inst_fetcher_pkg.sv - shared widths, enable levels and fetch FSM encoding
//
// Purpose: common definitions for inst_fetcher and its icache_dm sub-module.
// Ports:   none (package).

package inst_fetcher_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [ADDRESS_WIDTH-1:0] NULL = '0;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// rtl/inst_fetcher_icache_dm.sv - direct-mapped one-word-per-line instruction cache
//
// Purpose: tag/valid/data array with a combinational lookup port and one
//          synchronous write port. Valid bits clear asynchronously on reset;
//          tags and data are never reset because valid masks them.
// Ports:   clk_in, rst_in        clock, async active-high reset
//          rd_addr_in            lookup byte address
//          rd_hit_out            line valid and tag match
//          rd_data_out           line data (meaningful only on hit)
//          wr_en_in              fill strobe
//          wr_addr_in            fill byte address
//          wr_data_in            fill data

module icache_dm
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [ADDRESS_WIDTH-1:0]     rd_addr_in,
    output logic                         rd_hit_out,
    output logic [INSTRUCTION_WIDTH-1:0] rd_data_out,
    input  logic                         wr_en_in,
    input  logic [ADDRESS_WIDTH-1:0]     wr_addr_in,
    input  logic [INSTRUCTION_WIDTH-1:0] wr_data_in
);

    localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;
    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]             r_valid;
    logic [TAG_W-1:0]             r_tag  [LINES];
    logic [INSTRUCTION_WIDTH-1:0] r_data [LINES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [TAG_W-1:0] w_wr_tag;
    logic             w_unused_lsb;

    assign w_rd_idx = rd_addr_in[IDX_W+1:2];
    assign w_wr_idx = wr_addr_in[IDX_W+1:2];
    assign w_rd_tag = rd_addr_in[ADDRESS_WIDTH-1:IDX_W+2];
    assign w_wr_tag = wr_addr_in[ADDRESS_WIDTH-1:IDX_W+2];

    // Addresses are word aligned, so the byte-offset bits carry no information.
    assign w_unused_lsb = ^{rd_addr_in[1:0], wr_addr_in[1:0]};

    assign rd_hit_out  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign rd_data_out = r_data[w_rd_idx];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (wr_en_in) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= wr_data_in;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - instruction fetch stage: PC, icache lookup, miss FSM, queue push
//
// Purpose: holds the fetch PC, pushes one {inst, pc} per cycle on a cache hit
//          when the instruction queue has room, fetches missing words from the
//          memory controller, and restarts at the ROB target on flush.
// Ports:   clk_in, rst_in, rdy_in          clock, async active-high reset, global ready
//          rob_flush_in, rob_target_pc_in  redirect strobe and restart PC
//          iqueue_rdy_in                   queue has >= 2 free slots
//          iqueue_en_out/inst_out/pc_out   registered push strobe and payload
//          memctrl_en_out/addr_out         miss request, held until done
//          memctrl_done_in/inst_in         completion pulse and fetched word

module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                       ICACHE_IDX_W = 5,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = 32'h0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         rob_flush_in,
    input  logic [ADDRESS_WIDTH-1:0]     rob_target_pc_in,
    input  logic                         iqueue_rdy_in,
    output logic                         iqueue_en_out,
    output logic [INSTRUCTION_WIDTH-1:0] iqueue_inst_out,
    output logic [ADDRESS_WIDTH-1:0]     iqueue_pc_out,
    output logic                         memctrl_en_out,
    output logic [ADDRESS_WIDTH-1:0]     memctrl_addr_out,
    input  logic                         memctrl_done_in,
    input  logic [INSTRUCTION_WIDTH-1:0] memctrl_inst_in
);

    fetch_state_t                 r_state;
    logic [ADDRESS_WIDTH-1:0]     r_pc;
    logic                         r_iq_en;
    logic [INSTRUCTION_WIDTH-1:0] r_iq_inst;
    logic [ADDRESS_WIDTH-1:0]     r_iq_pc;
    logic                         r_mem_en;
    logic [ADDRESS_WIDTH-1:0]     r_mem_addr;

    logic                         w_hit;
    logic [INSTRUCTION_WIDTH-1:0] w_hit_data;
    logic                         w_fill;

    // The returned word is correct for its address even if a flush arrives
    // with it, so the fill ignores rob_flush_in.
    assign w_fill = rdy_in && (r_state == ST_WAIT_MEM) && memctrl_done_in;

    icache_dm #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rd_addr_in  (r_pc),
        .rd_hit_out  (w_hit),
        .rd_data_out (w_hit_data),
        .wr_en_in    (w_fill),
        .wr_addr_in  (r_mem_addr),
        .wr_data_in  (memctrl_inst_in)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_iq_en    <= DISABLE;
            r_iq_inst  <= NULL;
            r_iq_pc    <= NULL;
            r_mem_en   <= DISABLE;
            r_mem_addr <= NULL;
        end else if (rdy_in) begin
            r_iq_en <= DISABLE;
            if (rob_flush_in) begin
                // Dropping en aborts any outstanding request.
                r_pc     <= rob_target_pc_in;
                r_mem_en <= DISABLE;
                r_state  <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_hit) begin
                            if (iqueue_rdy_in) begin
                                r_iq_en   <= ENABLE;
                                r_iq_inst <= w_hit_data;
                                r_iq_pc   <= r_pc;
                                r_pc      <= r_pc + ADDRESS_WIDTH'(4);
                            end
                        end else begin
                            r_mem_en   <= ENABLE;
                            r_mem_addr <= r_pc;
                            r_state    <= ST_WAIT_MEM;
                        end
                    end
                    ST_WAIT_MEM: begin
                        // The word is pushed later by the hit path; no bypass.
                        if (memctrl_done_in) begin
                            r_mem_en <= DISABLE;
                            r_state  <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign iqueue_en_out    = r_iq_en;
    assign iqueue_inst_out  = r_iq_inst;
    assign iqueue_pc_out    = r_iq_pc;
    assign memctrl_en_out   = r_mem_en;
    assign memctrl_addr_out = r_mem_addr;

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - self-checking bench for inst_fetcher

module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_flush_in;
    logic [31:0] rob_target_pc_in;
    logic        iqueue_rdy_in;
    logic        iqueue_en_out;
    logic [31:0] iqueue_inst_out;
    logic [31:0] iqueue_pc_out;
    logic        memctrl_en_out;
    logic [31:0] memctrl_addr_out;
    logic        memctrl_done_in;
    logic [31:0] memctrl_inst_in;

    inst_fetcher dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .rob_flush_in     (rob_flush_in),
        .rob_target_pc_in (rob_target_pc_in),
        .iqueue_rdy_in    (iqueue_rdy_in),
        .iqueue_en_out    (iqueue_en_out),
        .iqueue_inst_out  (iqueue_inst_out),
        .iqueue_pc_out    (iqueue_pc_out),
        .memctrl_en_out   (memctrl_en_out),
        .memctrl_addr_out (memctrl_addr_out),
        .memctrl_done_in  (memctrl_done_in),
        .memctrl_inst_in  (memctrl_inst_in)
    );

    always #5 clk_in = ~clk_in;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;
    int          n_push = 0;
    int          n_req = 0;
    int          n_push_40 = 0;
    logic [31:0] last_req_addr;
    logic        mem_auto;
    logic        mem_rand;
    int          mem_lat;
    int          mem_cnt;
    time         done_drive_t;
    time         last_push_t;
    logic        prev_ien, prev_men;
    logic [31:0] prev_ipc, prev_iinst, prev_maddr;

    // Memory image seen by the fetcher.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic snap_prev();
        prev_ien   = iqueue_en_out;
        prev_ipc   = iqueue_pc_out;
        prev_iinst = iqueue_inst_out;
        prev_men   = memctrl_en_out;
        prev_maddr = memctrl_addr_out;
    endtask

    // One clock: act as memory controller, clock, then score the outputs.
    task automatic step();
        logic        rdy_e, qrdy_e, flush_e;
        logic [31:0] tgt_e;
        if (mem_auto) begin
            if (memctrl_en_out && rdy_in) begin
                if (mem_cnt >= mem_lat) begin
                    memctrl_done_in = 1'b1;
                    memctrl_inst_in = mem_word(memctrl_addr_out);
                    mem_cnt = 0;
                    if (mem_rand) mem_lat = $urandom_range(0, 4);
                end else begin
                    memctrl_done_in = 1'b0;
                    mem_cnt++;
                end
            end else begin
                memctrl_done_in = 1'b0;
                if (!memctrl_en_out) mem_cnt = 0;
            end
        end
        if (memctrl_done_in) done_drive_t = $time;
        rdy_e = rdy_in; qrdy_e = iqueue_rdy_in; flush_e = rob_flush_in; tgt_e = rob_target_pc_in;
        @(posedge clk_in);
        #1;
        if (!rdy_e) begin
            vectors++;
            if ({iqueue_en_out, iqueue_pc_out, iqueue_inst_out, memctrl_en_out, memctrl_addr_out} !==
                {prev_ien, prev_ipc, prev_iinst, prev_men, prev_maddr})
                $display("FAIL freeze: outputs %b %h %h %b %h changed while rdy_in low, required %b %h %h %b %h",
                         iqueue_en_out, iqueue_pc_out, iqueue_inst_out, memctrl_en_out, memctrl_addr_out,
                         prev_ien, prev_ipc, prev_iinst, prev_men, prev_maddr);
            if ({iqueue_en_out, iqueue_pc_out, iqueue_inst_out, memctrl_en_out, memctrl_addr_out} !==
                {prev_ien, prev_ipc, prev_iinst, prev_men, prev_maddr}) miscompares++;
        end else begin
            if (iqueue_en_out) begin
                n_push++;
                last_push_t = $time;
                if (iqueue_pc_out == 32'h40) n_push_40++;
                vectors++;
                if (iqueue_pc_out !== exp_pc) begin
                    miscompares++;
                    $display("FAIL push_pc: got %h required %h", iqueue_pc_out, exp_pc);
                end
                vectors++;
                if (iqueue_inst_out !== mem_word(iqueue_pc_out)) begin
                    miscompares++;
                    $display("FAIL push_inst: pc %h got %h required %h", iqueue_pc_out, iqueue_inst_out, mem_word(iqueue_pc_out));
                end
                vectors++;
                if (!qrdy_e || flush_e) begin
                    miscompares++;
                    $display("FAIL push_gate: push with iqueue_rdy=%b flush=%b, required iqueue_rdy=1 flush=0", qrdy_e, flush_e);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (memctrl_en_out && !prev_men) begin
                n_req++;
                last_req_addr = memctrl_addr_out;
                vectors++;
                if (memctrl_addr_out !== exp_pc) begin
                    miscompares++;
                    $display("FAIL req_addr: got %h required %h", memctrl_addr_out, exp_pc);
                end
            end else if (memctrl_en_out && prev_men) begin
                vectors++;
                if (memctrl_addr_out !== prev_maddr) begin
                    miscompares++;
                    $display("FAIL req_hold: addr got %h required %h", memctrl_addr_out, prev_maddr);
                end
            end
            if (flush_e) begin
                vectors++;
                if (memctrl_en_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_men: memctrl_en got %b required 0", memctrl_en_out);
                end
                exp_pc = tgt_e;
            end
        end
        snap_prev();
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        rob_flush_in = 1'b1;
        rob_target_pc_in = tgt;
        step();
        rob_flush_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; rob_flush_in = 1'b0; rob_target_pc_in = '0;
        iqueue_rdy_in = 1'b0; memctrl_done_in = 1'b0; memctrl_inst_in = '0;
        mem_auto = 1'b0; mem_rand = 1'b0; mem_lat = 3; mem_cnt = 0;
        repeat (2) @(posedge clk_in);
        #1;
        vectors++; if (iqueue_en_out !== 1'b0) begin miscompares++; $display("FAIL rst_iq_en: got %b required 0", iqueue_en_out); end
        vectors++; if (iqueue_inst_out !== 32'h0) begin miscompares++; $display("FAIL rst_iq_inst: got %h required 0", iqueue_inst_out); end
        vectors++; if (iqueue_pc_out !== 32'h0) begin miscompares++; $display("FAIL rst_iq_pc: got %h required 0", iqueue_pc_out); end
        vectors++; if (memctrl_en_out !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b required 0", memctrl_en_out); end
        vectors++; if (memctrl_addr_out !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h required 0", memctrl_addr_out); end
        @(negedge clk_in);
        rst_in = 1'b0;
        exp_pc = 32'h0;
        snap_prev();
    endtask

    task automatic test_cold_start();
        int guard = 0;
        iqueue_rdy_in = 1'b1; mem_auto = 1'b1; mem_lat = 3; mem_cnt = 0;
        while (n_push == 0 && guard < 40) begin step(); guard++; end
        vectors++; if (n_push == 0) begin miscompares++; $display("FAIL cold_timeout: no push in %0d cycles, required 1", guard); end
        vectors++; if (n_req !== 1) begin miscompares++; $display("FAIL cold_req_count: got %0d required 1", n_req); end
        vectors++; if (last_req_addr !== 32'h0) begin miscompares++; $display("FAIL cold_req_addr: got %h required 0", last_req_addr); end
        vectors++; if (iqueue_inst_out !== 32'h13) begin miscompares++; $display("FAIL cold_inst: got %h required 13", iqueue_inst_out); end
        vectors++; if (last_push_t - done_drive_t !== 64'd20) begin miscompares++; $display("FAIL cold_latency: push %0t after done, required 20", last_push_t - done_drive_t); end
    endtask

    task automatic test_streaming();
        int guard = 0;
        int req0;
        while (n_push < 8 && guard < 200) begin step(); guard++; end
        vectors++; if (n_push < 8) begin miscompares++; $display("FAIL warm_timeout: got %0d pushes required 8", n_push); end
        do_flush(32'h0);
        req0 = n_req;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (iqueue_en_out !== 1'b1 || iqueue_pc_out !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL stream_push: cycle %0d en %b pc %h required en 1 pc %h", i, iqueue_en_out, iqueue_pc_out, 32'(i * 4));
            end
        end
        vectors++; if (n_req !== req0) begin miscompares++; $display("FAIL stream_no_req: got %0d requests required 0", n_req - req0); end
    endtask

    task automatic test_backpressure();
        do_flush(32'h0);
        repeat (4) step();
        iqueue_rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (iqueue_en_out !== 1'b0 || memctrl_en_out !== 1'b0) begin
                miscompares++;
                $display("FAIL stall: cycle %0d iq_en %b mem_en %b required 0 0", i, iqueue_en_out, memctrl_en_out);
            end
        end
        iqueue_rdy_in = 1'b1;
        step();
        vectors++;
        if (iqueue_en_out !== 1'b1 || iqueue_pc_out !== 32'h10) begin
            miscompares++;
            $display("FAIL stall_resume: en %b pc %h required en 1 pc 10", iqueue_en_out, iqueue_pc_out);
        end
    endtask

    task automatic test_flush_mid_miss();
        int guard = 0;
        int p0, n40;
        mem_auto = 1'b0; memctrl_done_in = 1'b0;
        do_flush(32'h40);
        while (!memctrl_en_out && guard < 5) begin step(); guard++; end
        vectors++; if (memctrl_en_out !== 1'b1 || last_req_addr !== 32'h40) begin miscompares++; $display("FAIL miss40_req: en %b addr %h required 1 40", memctrl_en_out, last_req_addr); end
        repeat (2) step();
        n40 = n_push_40;
        do_flush(32'h100);
        vectors++; if (memctrl_en_out !== 1'b0) begin miscompares++; $display("FAIL abort_en: got %b required 0", memctrl_en_out); end
        mem_auto = 1'b1; mem_lat = 2; mem_cnt = 0;
        p0 = n_push; guard = 0;
        while (n_push == p0 && guard < 30) begin step(); guard++; end
        vectors++; if (last_req_addr !== 32'h100) begin miscompares++; $display("FAIL redirect_req: got %h required 100", last_req_addr); end
        vectors++; if (iqueue_pc_out !== 32'h100) begin miscompares++; $display("FAIL redirect_push: got %h required 100", iqueue_pc_out); end
        vectors++; if (n_push_40 !== n40) begin miscompares++; $display("FAIL abandoned_push: got %0d pushes of 40 required 0", n_push_40 - n40); end
    endtask

    task automatic test_done_with_flush();
        int guard = 0;
        int req0;
        mem_auto = 1'b0; memctrl_done_in = 1'b0;
        do_flush(32'h80);
        while (!memctrl_en_out && guard < 5) begin step(); guard++; end
        vectors++; if (last_req_addr !== 32'h80) begin miscompares++; $display("FAIL coinc_req: got %h required 80", last_req_addr); end
        step();
        memctrl_done_in = 1'b1;
        memctrl_inst_in = mem_word(32'h80);
        do_flush(32'h80);
        memctrl_done_in = 1'b0;
        vectors++; if (iqueue_en_out !== 1'b0) begin miscompares++; $display("FAIL coinc_no_push: got %b required 0", iqueue_en_out); end
        req0 = n_req;
        step();
        vectors++;
        if (iqueue_en_out !== 1'b1 || iqueue_pc_out !== 32'h80 || iqueue_inst_out !== mem_word(32'h80)) begin
            miscompares++;
            $display("FAIL coinc_hit: en %b pc %h inst %h required 1 80 %h", iqueue_en_out, iqueue_pc_out, iqueue_inst_out, mem_word(32'h80));
        end
        vectors++; if (n_req !== req0 || memctrl_en_out !== 1'b0) begin miscompares++; $display("FAIL coinc_no_req: en %b new %0d required 0 0", memctrl_en_out, n_req - req0); end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        int req0, p0;
        mem_auto = 1'b0; memctrl_done_in = 1'b0;
        while (!memctrl_en_out && guard < 5) begin step(); guard++; end
        vectors++; if (memctrl_en_out !== 1'b1) begin miscompares++; $display("FAIL areset_setup: mem_en %b required 1", memctrl_en_out); end
        #3;
        rst_in = 1'b1;
        #1;
        vectors++; if (memctrl_en_out !== 1'b0) begin miscompares++; $display("FAIL areset_drop: mem_en %b required 0", memctrl_en_out); end
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        exp_pc = 32'h0;
        snap_prev();
        mem_auto = 1'b1; mem_lat = 1; mem_cnt = 0;
        req0 = n_req; p0 = n_push; guard = 0;
        while (n_push == p0 && guard < 30) begin step(); guard++; end
        vectors++; if (n_req - req0 !== 1 || last_req_addr !== 32'h0) begin miscompares++; $display("FAIL areset_remiss: %0d requests last %h required 1 at 0", n_req - req0, last_req_addr); end
        vectors++; if (iqueue_pc_out !== 32'h0) begin miscompares++; $display("FAIL areset_push: pc %h required 0", iqueue_pc_out); end
    endtask

    task automatic test_random();
        mem_auto = 1'b1; mem_rand = 1'b1; mem_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            rdy_in = ($urandom_range(0, 19) != 0);
            iqueue_rdy_in = ($urandom_range(0, 3) != 0);
            rob_flush_in = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0)
                rob_target_pc_in = {28'hFFF_FFFF, 2'($urandom_range(0, 3)), 2'b00};
            else
                rob_target_pc_in = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            step();
        end
        rdy_in = 1'b1; rob_flush_in = 1'b0; iqueue_rdy_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_start();
        test_streaming();
        test_backpressure();
        test_flush_mid_miss();
        test_done_with_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage that sits directly upstream of the instruction queue. It holds the architectural fetch PC and looks up a small direct-mapped instruction cache. On a miss it requests a 32-bit word from the memory controller. It pushes one {instruction, PC} pair per cycle into the queue when the queue reports room, and restarts at a new PC when the ROB flushes.

## Interface
Parameters:
- `ICACHE_IDX_W`, default 5: cache index width, giving 2^5 = 32 one-word lines.
- `RESET_PC`, default 32'h0: fetch PC after reset.

Ports:
- `clk_in`  in  1: the single clock.
- `rst_in`  in  1: reset, asynchronous and active-high.
- `rdy_in`  in  1: global ready. When low, all state, including the cache, holds.
- `rob_flush_in`  in  1: mispredict or exception redirect.
- `rob_target_pc_in`  in  32: restart PC, valid with `rob_flush_in`.
- `iqueue_rdy_in`  in  1: queue has at least 2 free slots.
- `iqueue_en_out`  out  1: one-cycle push strobe.
- `iqueue_inst_out`  out  32: instruction word.
- `iqueue_pc_out`  out  32: PC of that instruction.
- `memctrl_en_out`  out  1: fetch request, held high until done.
- `memctrl_addr_out`  out  32: word address of the request.
- `memctrl_done_in`  in  1: one-cycle completion pulse.
- `memctrl_inst_in`  in  32: fetched word, valid with done.

## Operation
- Cache line layout: valid bit, tag = `pc[31:2+ICACHE_IDX_W]`, data[31:0].
  - Index = `pc[ICACHE_IDX_W+1:2]`.
  - `pc[1:0]` is always 0.
- FSM states are IDLE and WAIT_MEM. Reset enters IDLE.
- IDLE, no flush:
  - Hit and `iqueue_rdy_in`: register the push (en=1, inst=line data, pc=pc), then pc <= pc+4.
  - Hit and not `iqueue_rdy_in`: hold pc and push nothing.
  - Miss: drive `memctrl_en_out`=1 and `memctrl_addr_out`=pc, then go to WAIT_MEM. Queue readiness is not checked for a miss.
- WAIT_MEM:
  - Hold en and addr stable.
  - On `memctrl_done_in`: write the line (valid=1, tag, data), drop en, and return to IDLE.
  - The instruction is pushed by the hit path in a following cycle. No bypass.
- Flush, which has priority over everything except reset:
  - pc <= `rob_target_pc_in`.
  - `iqueue_en_out` <= 0 and `memctrl_en_out` <= 0.
  - FSM goes to IDLE.
  - If done arrives in the same cycle as the flush, the line is still written, because the data is correct for its address. Nothing is pushed.
- A flush in WAIT_MEM abandons the request. The memory controller treats en falling as an abort.
- `iqueue_en_out` defaults to 0 each cycle; it is a pulse, never a level.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- Cache contents persist across flushes. Only reset invalidates them: all valid bits are cleared.
- Reset values:
  - pc = `RESET_PC`, state IDLE.
  - `iqueue_en_out`=0, `iqueue_inst_out`=0, `iqueue_pc_out`=0.
  - `memctrl_en_out`=0, `memctrl_addr_out`=0.
  - All valid bits 0.
- Reset asserted mid-miss drops `memctrl_en_out` immediately and asynchronously.

## Timing
- Hit latency: 1 cycle. A PC that hits at edge N is pushed at edge N+1.
- Sustained throughput: 1 instruction per cycle while hitting and `iqueue_rdy_in`=1.
- The 2-slot margin on `iqueue_rdy_in` covers the one-cycle registered push. Two consecutive pushes are allowed after the queue signals ready.
- Miss cost: 1 cycle to issue the request, plus the memory latency, plus 1 cycle for the done edge back to IDLE, plus 1 cycle for the hit push.
- Flush takes effect at the edge where it is sampled. The first push of the target PC is 1 cycle later on a hit.
- `rdy_in`=0 freezes all registers. `iqueue_en_out` also holds, because the queue ignores it while not ready.

## Structure
- Shared package/define header holds:
  - `ADDRESS_WIDTH` and `INSTRUCTION_WIDTH` (32).
  - `ENABLE`/`DISABLE`.
  - `NULL`.
  - The FSM state encoding.
- Natural sub-module: `icache_dm`, a direct-mapped tag/valid/data array.
  - Combinational lookup: `hit` and `data` for an address.
  - One write port.
  - Asynchronous valid clear on reset.
- `inst_fetcher` keeps the PC, the FSM and the handshakes.

## Test plan
- **Cold start:** reset, then the memory returns 32'h0000_0013 for addr 0 after 3 cycles.
  - Exactly one request with addr=0.
  - The push (inst=0x13, pc=0) occurs 2 cycles after done.
- **Streaming hits:** addresses 0..0x1C are preloaded and `iqueue_rdy_in`=1.
  - 8 consecutive one-cycle pushes with pc=0,4,…,0x1C.
  - No memory requests.
- **Backpressure:** `iqueue_rdy_in` drops for 4 cycles on a hit at pc=0x10.
  - No pushes during the stall and pc holds at 0x10.
  - A push of 0x10 follows 1 cycle after ready returns.
- **Flush mid-miss:** a miss is pending at 0x40, then a flush to target 0x100.
  - `memctrl_en_out` falls at that edge.
  - The next request is addr=0x100.
  - No push with pc=0x40.
- **Done coincident with flush:** done for 0x80 arrives in the same cycle as a flush to 0x80.
  - No push in that cycle.
  - The next cycle pushes pc=0x80 from the cache, with no new request.
- **Async reset mid-miss:** assert `rst_in` between clock edges.
  - `memctrl_en_out` drops immediately.
  - After release, addr 0 misses again, confirming the valid bits were cleared.
